// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel divider, sync decode and pixel-tick delay line
module vga_timing_gen #(
    parameter int CW        = 10,
    parameter int HACTIVE   = 640,
    parameter int HFRONT    = 16,
    parameter int HSYNC     = 96,
    parameter int HBACK     = 48,
    parameter int VACTIVE   = 480,
    parameter int VFRONT    = 10,
    parameter int VSYNC     = 2,
    parameter int VBACK     = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CLK_DIV   = 2,
    parameter int PIPE      = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    output logic          pixelTick,
    output logic          hSync,
    output logic          vSync,
    output logic          bright,
    output logic [CW-1:0] hCount,
    output logic [CW-1:0] vCount,
    output logic          lineStart,
    output logic          frameStart
);
    localparam int HTOTAL = HACTIVE + HFRONT + HSYNC + HBACK;
    localparam int VTOTAL = VACTIVE + VFRONT + VSYNC + VBACK;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] H_ACT = CW'(HACTIVE);
    localparam logic [CW-1:0] V_ACT = CW'(VACTIVE);
    localparam logic [CW-1:0] H_SS = CW'(HACTIVE + HFRONT);
    localparam logic [CW-1:0] H_SE = CW'(HACTIVE + HFRONT + HSYNC);
    localparam logic [CW-1:0] V_SS = CW'(VACTIVE + VFRONT);
    localparam logic [CW-1:0] V_SE = CW'(VACTIVE + VFRONT + VSYNC);
    localparam logic HP = HSYNC_POL != 0;
    localparam logic VP = VSYNC_POL != 0;
    localparam logic [2:0] IDLE = {~HP, ~VP, 1'b0};

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [PIPE:0][2:0] pipe_q, pipe_d;
    logic line_q, line_d, frame_q, frame_d;
    logic tick, h_wrap;
    logic [2:0] raw;

    // stage 0 holds the decode of the next counts; stage PIPE drives the pins
    always_comb begin
        tick = enable && div_q == D_LAST;
        h_wrap = h_q == H_LAST;
        div_d = enable ? (div_q == D_LAST ? '0 : div_q + 1'b1) : div_q;
        h_d = tick ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
        v_d = tick && h_wrap ? (v_q == V_LAST ? '0 : v_q + 1'b1) : v_q;
        raw = {(h_d >= H_SS && h_d < H_SE) ? HP : ~HP,
               (v_d >= V_SS && v_d < V_SE) ? VP : ~VP,
               h_d < H_ACT && v_d < V_ACT};
        pipe_d = pipe_q;
        if (tick) begin
            pipe_d[0] = raw;
            for (int i = 1; i <= PIPE; i++) pipe_d[i] = pipe_q[i-1];
        end
        line_d = tick && h_wrap;
        frame_d = line_d && v_q == V_LAST;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            pipe_q  <= {(PIPE + 1){IDLE}};
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pipe_q  <= pipe_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign pixelTick  = tick;
    assign hSync      = pipe_q[PIPE][2];
    assign vSync      = pipe_q[PIPE][1];
    assign bright     = pipe_q[PIPE][0];
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign lineStart  = line_q && enable;
    assign frameStart = frame_q && enable;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the next generation of the display controller's sync block. It divides the system clock into a pixel-rate tick and walks horizontal/vertical position counters through active, front-porch, sync and back-porch regions, with every region length and sync polarity set by parameter. It registers hSync, vSync and bright, with an optional pixel-tick delay line to compensate for downstream glyph/bitmap fetch latency. It also emits line/frame start strobes and sits between the top-level VGA module and the bit generator.

## Interface
- CW, 10: width of hCount/vCount; must hold HTOTAL-1 and VTOTAL-1
- HACTIVE, 640 / HFRONT, 16 / HSYNC, 96 / HBACK, 48: horizontal region lengths in pixels (each ≥1); HTOTAL = sum = 800
- VACTIVE, 480 / VFRONT, 10 / VSYNC, 2 / VBACK, 33: vertical region lengths in lines (each ≥1); VTOTAL = sum = 525
- HSYNC_POL, 0 / VSYNC_POL, 0: asserted level of hSync / vSync (0 = active low)
- CLK_DIV, 2: system clocks per pixel (≥1); 2 gives 25 MHz from 50 MHz
- PIPE, 0: pixel-tick delay (0..7) applied to hSync, vSync, bright only
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  1 = run; 0 = freeze all state
- pixelTick  out  1  high for one clock per pixel period
- hSync, vSync  out  1  sync outputs at the programmed polarity, registered
- bright  out  1  1 when the (delayed) position is inside the active area, registered
- hCount, vCount  out  CW  current pixel column / line, registered, undelayed
- lineStart  out  1  one-clock strobe at the start of each line
- frameStart  out  1  one-clock strobe at the start of each frame

## Operation
- Each line runs active → front porch → sync → back porch: hCount 0..HACTIVE-1 is active; sync covers HACTIVE+HFRONT .. HACTIVE+HFRONT+HSYNC-1. Vertical uses the same ordering on vCount.
- Divider counts 0..CLK_DIV-1 while enable=1. pixelTick = enable && (div == CLK_DIV-1). For CLK_DIV=1, pixelTick = enable.
- On a clock edge with pixelTick=1, hCount increments. At HTOTAL-1 it wraps to 0 and vCount increments on the same edge. vCount wraps VTOTAL-1 → 0 on that same edge.
- Undelayed decode: brightRaw = (hCount<HACTIVE)&&(vCount<VACTIVE). The sync terms are asserted inside their sync windows. Decode is computed from next-state counts and registered, so with PIPE=0 it is aligned cycle-exactly with hCount/vCount.
- PIPE>0: hSync/vSync/bright pass through a PIPE-stage shift register that advances only on pixelTick edges. hCount/vCount are never delayed.
- lineStart = 1 only for the first clock in which hCount==0 after a wrap. frameStart is the same, but additionally requires vCount==0.
- enable=0: divider, counters and pipeline hold; pixelTick, lineStart and frameStart are 0. Other outputs hold.

## Timing
- Reset state (any edge with reset=1, including mid-frame):
  - div=0; hCount=HTOTAL-1, vCount=VTOTAL-1 (back porch corner).
  - bright=0; hSync=!HSYNC_POL, vSync=!VSYNC_POL; all pipeline stages hold these inactive values.
  - pixelTick=0 registered portion, lineStart=0, frameStart=0.
- After reset release with enable=1: the first pixelTick occurs CLK_DIV-1 clocks later. The edge it qualifies moves counts to (0,0), and lineStart and frameStart are high for the following clock.
- Counts and undelayed outputs change only on pixelTick edges. Period is CLK_DIV clocks per pixel, HTOTAL·CLK_DIV per line, HTOTAL·VTOTAL·CLK_DIV per frame.
- vSync transitions coincide with the hCount 0 edge of the line where vCount enters or leaves the window.
- Latency from position to delayed outputs: PIPE pixel ticks (PIPE·CLK_DIV clocks while enabled).

## Test plan
- Reset at defaults, then hold reset 5 clocks -> hCount=799, vCount=524, bright=0, hSync=1, vSync=1, strobes 0. Release -> counts reach (0,0) 2 clocks later with frameStart=lineStart=1 for 1 clock.
- Horizontal sweep, defaults -> hCount steps every 2 clocks; bright=1 exactly for hCount 0..639 on line 0; hSync=0 exactly for hCount 656..751 (192 clocks); line length 1600 clocks.
- Full frame, defaults -> vSync=0 exactly for vCount 490..491; bright=0 for vCount 480..524; frameStart pulses exactly 840000 clocks apart; one lineStart per 1600 clocks.
- PIPE=2, CLK_DIV=1, HSYNC_POL=1 -> bright rises 2 clocks after hCount becomes 0; hSync=1 for hCount 658..753; hCount/vCount undelayed.
- enable=0 for 7 clocks mid-line (hCount=300) -> counts, bright and syncs frozen; pixelTick and strobes 0; resume continues from hCount=300 with no skipped pixel.
- Reset asserted at hCount=700, vCount=490 (vSync active) -> next edge vSync=1, counts 799/524, pipeline cleared; normal restart as in the first scenario.
